// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register addresses, MTC0 write masks, ExcCodes and field positions.
package cp0_pkg;

  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;
  localparam logic [7:0] ADDR_EBASE    = 8'h79;

  localparam logic [31:0] MASK_STATUS = 32'h1040_FF17;
  localparam logic [31:0] MASK_CAUSE  = 32'h0080_0300;
  localparam logic [31:0] MASK_EBASE  = 32'h3FFF_F000;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam int unsigned ST_IE   = 0;
  localparam int unsigned ST_EXL  = 1;
  localparam int unsigned ST_ERL  = 2;
  localparam int unsigned ST_BEV  = 22;
  localparam int unsigned CA_BD   = 31;
  localparam int unsigned CA_TI   = 30;
  localparam int unsigned CA_IP7  = 15;
  localparam int unsigned CA_EXC  = 2;

  localparam logic [31:0] VEC_BEV = 32'hBFC0_0380;
  localparam logic [11:0] VEC_OFF = 12'h180;

  // Software-writable bits of the register at a CP0 address (0 = read-only or unmapped).
  function automatic logic [31:0] wr_mask(input logic [7:0] addr);
    case (addr)
      ADDR_COUNT, ADDR_COMPARE, ADDR_EPC: wr_mask = '1;
      ADDR_STATUS: wr_mask = MASK_STATUS;
      ADDR_CAUSE:  wr_mask = MASK_CAUSE;
      ADDR_EBASE:  wr_mask = MASK_EBASE;
      default:     wr_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/cp0_exc_arbiter.sv
// Fixed-priority select among commit-slot exceptions; slot 0 is the oldest and wins.
module cp0_exc_arbiter #(
  parameter int ISSUE_W = 2
) (
  input  logic [ISSUE_W-1:0]    exc_valid,
  input  logic [5*ISSUE_W-1:0]  exc_code,
  input  logic [32*ISSUE_W-1:0] exc_pc,
  input  logic [ISSUE_W-1:0]    exc_bd,
  input  logic [32*ISSUE_W-1:0] exc_badaddr,
  output logic                  sel_valid,
  output logic [((ISSUE_W > 1) ? $clog2(ISSUE_W) : 1)-1:0] sel_idx,
  output logic [4:0]            sel_code,
  output logic [31:0]           sel_pc,
  output logic                  sel_bd,
  output logic [31:0]           sel_badaddr
);
  import cp0_pkg::*;

  localparam int IW = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;

  // Pick the lowest-index valid slot and mux its attributes.
  always_comb begin
    sel_valid   = 1'b0;
    sel_idx     = '0;
    sel_code    = '0;
    sel_pc      = '0;
    sel_bd      = 1'b0;
    sel_badaddr = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      if (exc_valid[i] && !sel_valid) begin
        sel_valid   = 1'b1;
        sel_idx     = IW'(i);
        sel_code    = exc_code[5*i +: 5];
        sel_pc      = exc_pc[32*i +: 32];
        sel_bd      = exc_bd[i];
        sel_badaddr = exc_badaddr[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor-0: CP0 register file, Count/Compare timer, interrupt request, exception commit and ERET.
module cp0_ctrl #(
  parameter int          ISSUE_W    = 2,
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EBASE_RST  = 32'h8000_0000,
  parameter logic [31:0] STATUS_RST = 32'h0040_0004
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_HW_INT-1:0]   hw_int,
  input  logic [7:0]              rd_addr,
  output logic [31:0]             rdata,
  input  logic                    wr_en,
  input  logic [7:0]              wr_addr,
  input  logic [31:0]             wr_data,
  input  logic [ISSUE_W-1:0]      exc_valid,
  input  logic [5*ISSUE_W-1:0]    exc_code,
  input  logic [32*ISSUE_W-1:0]   exc_pc,
  input  logic [ISSUE_W-1:0]      exc_bd,
  input  logic [ISSUE_W-1:0]      exc_bad_en,
  input  logic [32*ISSUE_W-1:0]   exc_badaddr,
  input  logic                    eret,
  output logic                    int_req,
  output logic                    exc_taken,
  output logic [31:0]             exc_vector,
  output logic [31:0]             epc_out,
  output logic                    exl
);
  import cp0_pkg::*;

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int IW = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;

  logic [31:0] badvaddr, count, compare, status, cause, epc, ebase;
  logic [31:0] badvaddr_n, count_n, compare_n, status_n, cause_n, epc_n, ebase_n;
  logic [PW-1:0] presc, presc_n;
  logic          int_req_n, exc_taken_n;
  logic [31:0]   exc_vector_n;

  logic          arb_valid;
  logic [IW-1:0] arb_idx;
  logic [4:0]    arb_code;
  logic [31:0]   arb_pc, arb_badaddr;
  logic          arb_bd, arb_bad_en;

  logic [31:0] cur_rd, rd_mask, wmask, count_inc;
  logic [5:0]  hw_ext;
  logic        tick, wr_count;

  cp0_exc_arbiter #(.ISSUE_W(ISSUE_W)) u_arb (
    .exc_valid   (exc_valid),
    .exc_code    (exc_code),
    .exc_pc      (exc_pc),
    .exc_bd      (exc_bd),
    .exc_badaddr (exc_badaddr),
    .sel_valid   (arb_valid),
    .sel_idx     (arb_idx),
    .sel_code    (arb_code),
    .sel_pc      (arb_pc),
    .sel_bd      (arb_bd),
    .sel_badaddr (arb_badaddr)
  );

  assign arb_bad_en = exc_bad_en[arb_idx];

  // Read mux with same-cycle MTC0 bypass (masked merge of write data over the stored value).
  always_comb begin
    case (rd_addr)
      ADDR_BADVADDR: cur_rd = badvaddr;
      ADDR_COUNT:    cur_rd = count;
      ADDR_COMPARE:  cur_rd = compare;
      ADDR_STATUS:   cur_rd = status;
      ADDR_CAUSE:    cur_rd = cause;
      ADDR_EPC:      cur_rd = epc;
      ADDR_EBASE:    cur_rd = ebase;
      default:       cur_rd = '0;
    endcase
    rd_mask = wr_mask(rd_addr);
    if (wr_en && (wr_addr == rd_addr))
      rdata = (wr_data & rd_mask) | (cur_rd & ~rd_mask);
    else
      rdata = cur_rd;
  end

  // Next-state: hardware updates first, then MTC0, ERET and exception override in rising priority.
  always_comb begin
    badvaddr_n = badvaddr;
    count_n    = count;
    compare_n  = compare;
    status_n   = status;
    cause_n    = cause;
    epc_n      = epc;
    ebase_n    = ebase;
    presc_n    = presc;
    hw_ext     = '0;
    hw_ext[NUM_HW_INT-1:0] = hw_int;
    wmask      = wr_mask(wr_addr);
    count_inc  = count + 32'd1;
    wr_count   = wr_en && (wr_addr == ADDR_COUNT);
    tick       = (presc == PW'(COUNT_DIV - 1));

    if (tick) begin
      presc_n = '0;
      count_n = count_inc;
    end else begin
      presc_n = presc + PW'(1);
    end
    // An MTC0 Count replaces the increment, so no Compare match occurs that cycle.
    if (tick && !wr_count && (count_inc == compare))
      cause_n[CA_TI] = 1'b1;
    cause_n[14:10] = hw_ext[4:0];

    if (wr_en) begin
      case (wr_addr)
        ADDR_COUNT: begin
          count_n = wr_data;
          presc_n = '0;
        end
        ADDR_COMPARE: begin
          compare_n      = wr_data;
          cause_n[CA_TI] = 1'b0;
        end
        ADDR_STATUS: status_n = (wr_data & wmask) | (status_n & ~wmask);
        ADDR_CAUSE:  cause_n  = (wr_data & wmask) | (cause_n & ~wmask);
        ADDR_EPC:    epc_n    = wr_data;
        ADDR_EBASE:  ebase_n  = (wr_data & wmask) | (ebase_n & ~wmask);
        default: ;
      endcase
    end

    if (eret && !arb_valid) begin
      if (status[ST_ERL]) status_n[ST_ERL] = 1'b0;
      else                status_n[ST_EXL] = 1'b0;
    end

    if (arb_valid) begin
      if (!status[ST_EXL]) begin
        epc_n          = arb_pc;
        cause_n[CA_BD] = arb_bd;
      end
      cause_n[CA_EXC +: 5] = arb_code;
      if (arb_bad_en) badvaddr_n = arb_badaddr;
      status_n[ST_EXL] = 1'b1;
    end

    // IP7 folds the timer in after every TI update has been resolved.
    cause_n[CA_IP7] = hw_ext[5] | cause_n[CA_TI];

    int_req_n    = status[ST_IE] & ~status[ST_EXL] & ~status[ST_ERL] &
                   (|(cause[15:8] & status[15:8]));
    exc_taken_n  = arb_valid;
    exc_vector_n = exc_vector;
    if (arb_valid)
      exc_vector_n = status[ST_BEV] ? VEC_BEV : {ebase[31:12], VEC_OFF};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr   <= '0;
      count      <= '0;
      compare    <= '0;
      status     <= STATUS_RST;
      cause      <= '0;
      epc        <= '0;
      ebase      <= EBASE_RST;
      presc      <= '0;
      int_req    <= 1'b0;
      exc_taken  <= 1'b0;
      exc_vector <= '0;
    end else begin
      badvaddr   <= badvaddr_n;
      count      <= count_n;
      compare    <= compare_n;
      status     <= status_n;
      cause      <= cause_n;
      epc        <= epc_n;
      ebase      <= ebase_n;
      presc      <= presc_n;
      int_req    <= int_req_n;
      exc_taken  <= exc_taken_n;
      exc_vector <= exc_vector_n;
    end
  end

  assign epc_out = epc;
  assign exl     = status[ST_EXL];

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl with hand-computed expectations.
module tb_cp0_ctrl;

  localparam logic [7:0] A_BADV = 8'h40, A_COUNT = 8'h48, A_CMP = 8'h58, A_STATUS = 8'h60,
                         A_CAUSE = 8'h68, A_EPC = 8'h70, A_EBASE = 8'h79;

  logic         clk = 1'b0;
  logic         reset;
  logic [5:0]   hw_int;
  logic [7:0]   rd_addr;
  logic [31:0]  rdata;
  logic         wr_en;
  logic [7:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [1:0]   exc_valid;
  logic [9:0]   exc_code;
  logic [63:0]  exc_pc;
  logic [1:0]   exc_bd;
  logic [1:0]   exc_bad_en;
  logic [63:0]  exc_badaddr;
  logic         eret;
  logic         int_req, exc_taken, exl;
  logic [31:0]  exc_vector, epc_out;

  int checks = 0;
  int failures = 0;
  logic [31:0] d;

  cp0_ctrl #(.ISSUE_W(2), .NUM_HW_INT(6), .COUNT_DIV(2),
             .EBASE_RST(32'h8000_0000), .STATUS_RST(32'h0040_0004)) dut (
    .clk(clk), .reset(reset), .hw_int(hw_int), .rd_addr(rd_addr), .rdata(rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_bad_en(exc_bad_en), .exc_badaddr(exc_badaddr), .eret(eret),
    .int_req(int_req), .exc_taken(exc_taken), .exc_vector(exc_vector),
    .epc_out(epc_out), .exl(exl)
  );

  always #50 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    rd_addr = a;
    #1;
    v = rdata;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] v);
    wr_en = 1'b1; wr_addr = a; wr_data = v;
    step();
    wr_en = 1'b0;
  endtask

  task automatic clear_exc();
    exc_valid = '0; exc_code = '0; exc_pc = '0; exc_bd = '0;
    exc_bad_en = '0; exc_badaddr = '0; eret = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hw_int = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    clear_exc();
    step(); step();

    // Reset values
    rd(A_COUNT, d);  check_eq("rst_count", d, 32'h0);
    rd(A_STATUS, d); check_eq("rst_status", d, 32'h0040_0004);
    rd(A_EBASE, d);  check_eq("rst_ebase", d, 32'h8000_0000);
    rd(A_CAUSE, d);  check_eq("rst_cause", d, 32'h0);
    rd(A_EPC, d);    check_eq("rst_epc", d, 32'h0);
    check_eq("rst_int_req", {31'b0, int_req}, 32'h0);
    check_eq("rst_exc_taken", {31'b0, exc_taken}, 32'h0);
    check_eq("rst_exc_vector", exc_vector, 32'h0);
    reset = 1'b0;

    // Timer: Count=0, Compare=5, COUNT_DIV=2 -> Count reaches 5 ten edges after the Count load
    mtc0(A_COUNT, 32'h0);
    mtc0(A_CMP, 32'h5);
    repeat (8) step();
    rd(A_COUNT, d); check_eq("count_at_4", d, 32'h4);
    rd(A_CAUSE, d); check_eq("ti_before", {31'b0, d[30]}, 32'h0);
    step();
    rd(A_COUNT, d); check_eq("count_at_5", d, 32'h5);
    rd(A_CAUSE, d);
    check_eq("ti_set", {31'b0, d[30]}, 32'h1);
    check_eq("ip7_set", {31'b0, d[15]}, 32'h1);

    // Interrupt request: IE=1, IM7=1, ERL cleared
    mtc0(A_STATUS, 32'h0000_8001);
    step();
    check_eq("int_req_on", {31'b0, int_req}, 32'h1);
    mtc0(A_STATUS, 32'h0000_8003);
    step();
    check_eq("int_req_exl", {31'b0, int_req}, 32'h0);

    // MTC0 Compare clears TI and IP7
    mtc0(A_CMP, 32'h9);
    rd(A_CAUSE, d);
    check_eq("ti_clr", {31'b0, d[30]}, 32'h0);
    check_eq("ip7_clr", {31'b0, d[15]}, 32'h0);

    // Dual exception, slot 0 older; BEV=1, EXL=0
    mtc0(A_STATUS, 32'h0040_0000);
    exc_valid = 2'b11; exc_code = {5'h08, 5'h04}; exc_pc = {32'h104, 32'h100};
    exc_bd = 2'b01; exc_bad_en = 2'b11; exc_badaddr = {32'h1111_1111, 32'hDEAD_0000};
    step();
    clear_exc();
    check_eq("excA_taken", {31'b0, exc_taken}, 32'h1);
    check_eq("excA_vector", exc_vector, 32'hBFC0_0380);
    check_eq("excA_epc", epc_out, 32'h100);
    check_eq("excA_exl", {31'b0, exl}, 32'h1);
    rd(A_CAUSE, d);
    check_eq("excA_code", {27'b0, d[6:2]}, 32'h4);
    check_eq("excA_bd", {31'b0, d[31]}, 32'h1);
    rd(A_BADV, d); check_eq("excA_badv", d, 32'hDEAD_0000);
    step();
    check_eq("excA_pulse_end", {31'b0, exc_taken}, 32'h0);
    check_eq("excA_vec_hold", exc_vector, 32'hBFC0_0380);

    // Nested exception: BEV=0, EXL=1 -> EPC/BD kept, EBase vector
    mtc0(A_STATUS, 32'h0000_0002);
    exc_valid = 2'b10; exc_code = {5'h0C, 5'h00}; exc_pc = {32'h200, 32'h0};
    step();
    clear_exc();
    check_eq("excB_taken", {31'b0, exc_taken}, 32'h1);
    check_eq("excB_epc", epc_out, 32'h100);
    check_eq("excB_vector", exc_vector, 32'h8000_0180);
    rd(A_CAUSE, d);
    check_eq("excB_code", {27'b0, d[6:2]}, 32'h0C);
    check_eq("excB_bd", {31'b0, d[31]}, 32'h1);
    rd(A_BADV, d); check_eq("excB_badv", d, 32'hDEAD_0000);

    // Same-cycle write bypass on Status
    wr_en = 1'b1; wr_addr = A_STATUS; wr_data = 32'hFFFF_FFFF;
    rd(A_STATUS, d); check_eq("bypass_status", d, 32'h1040_FF17);
    step();
    wr_en = 1'b0;

    // ERET together with exception: exception wins
    eret = 1'b1; exc_valid = 2'b01; exc_code = {5'h00, 5'h0D}; exc_pc = {32'h0, 32'h300};
    step();
    clear_exc();
    rd(A_STATUS, d); check_eq("eret_exc_status", d, 32'h1040_FF17);
    check_eq("eret_exc_exl", {31'b0, exl}, 32'h1);
    check_eq("eret_exc_taken", {31'b0, exc_taken}, 32'h1);
    check_eq("eret_exc_epc", epc_out, 32'h100);

    // ERET clears ERL first, then EXL
    eret = 1'b1; step();
    rd(A_STATUS, d); check_eq("eret_erl", d, 32'h1040_FF13);
    step(); eret = 1'b0;
    rd(A_STATUS, d); check_eq("eret_exl", d, 32'h1040_FF11);
    check_eq("eret_exl_out", {31'b0, exl}, 32'h0);

    // Read-only BadVAddr and unmapped address
    wr_en = 1'b1; wr_addr = A_BADV; wr_data = 32'h1234_5678;
    rd(A_BADV, d); check_eq("badv_bypass_ro", d, 32'hDEAD_0000);
    step(); wr_en = 1'b0;
    rd(A_BADV, d); check_eq("badv_ro", d, 32'hDEAD_0000);
    rd(8'h00, d);  check_eq("unmapped", d, 32'h0);

    // EBase / EPC writes
    mtc0(A_EBASE, 32'hFFFF_FFFF);
    rd(A_EBASE, d); check_eq("ebase_mask", d, 32'hBFFF_F000);
    mtc0(A_EPC, 32'h1234_5678);
    check_eq("epc_write", epc_out, 32'h1234_5678);

    // Hardware interrupt line sampled into Cause.IP2
    hw_int = 6'b000001; step(); hw_int = '0;
    rd(A_CAUSE, d); check_eq("hw_ip2", {31'b0, d[10]}, 32'h1);

    // Count 32-bit wrap
    mtc0(A_COUNT, 32'hFFFF_FFFF);
    rd(A_COUNT, d); check_eq("count_load", d, 32'hFFFF_FFFF);
    step(); step();
    rd(A_COUNT, d); check_eq("count_wrap", d, 32'h0);

    // Reset mid-operation with TI pending and an exception committing
    mtc0(A_COUNT, 32'h1233);
    mtc0(A_CMP, 32'h1234);
    step();
    rd(A_COUNT, d); check_eq("pre_rst_count", d, 32'h1234);
    rd(A_CAUSE, d); check_eq("pre_rst_ti", {31'b0, d[30]}, 32'h1);
    reset = 1'b1; exc_valid = 2'b01; exc_code = {5'h00, 5'h04}; exc_pc = {32'h0, 32'h400};
    step();
    reset = 1'b0; clear_exc();
    rd(A_COUNT, d);  check_eq("mid_rst_count", d, 32'h0);
    rd(A_CAUSE, d);  check_eq("mid_rst_cause", d, 32'h0);
    rd(A_STATUS, d); check_eq("mid_rst_status", d, 32'h0040_0004);
    rd(A_CMP, d);    check_eq("mid_rst_compare", d, 32'h0);
    check_eq("mid_rst_exc_taken", {31'b0, exc_taken}, 32'h0);
    check_eq("mid_rst_vector", exc_vector, 32'h0);
    check_eq("mid_rst_epc", epc_out, 32'h0);
    check_eq("mid_rst_int_req", {31'b0, int_req}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
